// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// the active-low hex glyph table and the legal parameter ranges.
package sseg_scan_ctrl_pkg;

    localparam int NUM_DIGITS_MIN   = 2;
    localparam int NUM_DIGITS_MAX   = 16;
    localparam int SLOT_LOG2_MIN    = 4;
    localparam int SLOT_LOG2_MAX    = 24;
    localparam int BRIGHT_BITS_MIN  = 1;
    localparam int BLINK_FRAMES_MIN = 1;

    // Active-low segments, bit 0 = a ... bit 6 = g; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sseg_scan_ctrl_glyph.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module sseg_glyph
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the glyph for the current nibble.
    always_comb begin
        seg = GLYPH_TBL[hex];
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices NUM_DIGITS digits,
// with PWM brightness, leading-zero suppression, blinking and a shadowed,
// frame-synchronous update of all display inputs.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_LOG2    = 17,
    parameter int BRIGHT_BITS  = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    blank_lz,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    update,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              sseg,
    output logic                    DP,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

    logic [SLOT_LOG2-1:0]    cnt;
    logic [SEL_W-1:0]        sel;
    logic [FR_W-1:0]         frame_cnt;
    logic                    phase;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_blank_lz;
    logic [BRIGHT_BITS-1:0]  sh_bright;

    logic                    cnt_last;
    logic                    boundary;
    logic                    load;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [3:0]              cur_hex;
    logic [6:0]              glyph_seg;
    logic                    lit;

    assign cnt_last = &cnt;
    assign boundary = cnt_last && (sel == SEL_LAST);
    assign load     = boundary && (pending || update);

    // Slot timer, digit select and blink frame counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            sel       <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt_last) begin
                sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end
            if (boundary) begin
                if (frame_cnt == FR_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Update request held until the frame boundary, then shadows load together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending     <= 1'b0;
            frame_start <= 1'b0;
            sh_digits   <= '0;
            sh_en       <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            sh_blank_lz <= 1'b0;
            sh_bright   <= '0;
        end else begin
            pending     <= boundary ? 1'b0 : (pending | update);
            frame_start <= load;
            if (load) begin
                sh_digits   <= digits;
                sh_en       <= digit_en;
                sh_dp       <= dp;
                sh_blink    <= blink;
                sh_blank_lz <= blank_lz;
                sh_bright   <= brightness;
            end
        end
    end

    // Leading-zero mask: a digit is blank when it and all higher digits are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (sh_digits[4*i +: 4] == 4'h0);
            lz_blank[i] = sh_blank_lz && zero_run && (i != 0);
        end
    end

    // Decide whether the selected digit lights this cycle.
    always_comb begin
        cur_hex = sh_digits[4*sel +: 4];
        lit     = sh_en[sel] && !lz_blank[sel] && !(phase && sh_blink[sel]) &&
                  (cnt != '0) &&
                  (cnt[SLOT_LOG2-1 -: BRIGHT_BITS] <= sh_bright);
    end

    sseg_glyph u_glyph (
        .hex (cur_hex),
        .seg (glyph_seg)
    );

    // Registered drivers; a dark cycle drives every line inactive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            AN   <= '1;
            sseg <= 7'h7F;
            DP   <= 1'b1;
        end else if (lit) begin
            AN   <= ~(NUM_DIGITS'(1) << sel);
            sseg <= glyph_seg;
            DP   <= ~sh_dp[sel];
        end else begin
            AN   <= '1;
            sseg <= 7'h7F;
            DP   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with a small configuration; every cycle is compared
// against a reference computed from the elapsed cycle count since reset.
module tb_sseg_scan_ctrl;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int BF    = 2;
    localparam int SLOT  = 1 << S;
    localparam int FRAME = SLOT * N;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   digits;
    logic [3:0]    digit_en;
    logic [3:0]    dp_in;
    logic [3:0]    blink;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic          update;
    logic [3:0]    dut_an;
    logic [6:0]    dut_sseg;
    logic          dut_dp;
    logic          dut_pending;
    logic          dut_frame_start;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int          m_t;
    bit          m_pend;
    logic [15:0] m_dig;
    logic [3:0]  m_en;
    logic [3:0]  m_dp;
    logic [3:0]  m_blink;
    bit          m_lz;
    logic [1:0]  m_br;

    sseg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_LOG2    (S),
        .BRIGHT_BITS  (B),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits      (digits),
        .digit_en    (digit_en),
        .dp          (dp_in),
        .blink       (blink),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .update      (update),
        .AN          (dut_an),
        .sseg        (dut_sseg),
        .DP          (dut_dp),
        .pending     (dut_pending),
        .frame_start (dut_frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t m_t=%0d got=%h want=%h", tag, $time, m_t, act, exp);
        end
    endtask

    // Segments lit (active-high, gfedcba) for each hex value.
    function automatic logic [6:0] segs_on(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // One clock: predict, clock, compare, advance the model. Entered and left at negedge.
    task automatic step();
        bit         rst;
        int         cn, sl, fr;
        bit         ph, lit, bnd, ld;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_pend, e_fs;
        rst = !reset_n;
        ld  = 1'b0;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_pend = 1'b0; e_fs = 1'b0;
        end else begin
            cn  = m_t % SLOT;
            sl  = (m_t / SLOT) % N;
            fr  = m_t / FRAME;
            ph  = ((fr / BF) % 2) == 1;
            lit = m_en[sl] &&
                  !(m_lz && sl != 0 && (m_dig >> (4 * sl)) == 16'h0) &&
                  !(ph && m_blink[sl]) &&
                  cn != 0 && (cn >> (S - B)) <= int'(m_br);
            e_an  = lit ? (4'hF & ~(4'b0001 << sl)) : 4'hF;
            e_seg = lit ? ~segs_on(4'((m_dig >> (4 * sl)) & 16'hF)) : 7'h7F;
            e_dp  = lit ? ~m_dp[sl] : 1'b1;
            bnd   = (cn == SLOT - 1) && (sl == N - 1);
            ld    = bnd && (m_pend || update);
            e_pend = bnd ? 1'b0 : (m_pend || update);
            e_fs   = ld;
        end
        @(posedge clk);
        #1;
        chk("an",          32'(dut_an),          32'(e_an));
        chk("sseg",        32'(dut_sseg),        32'(e_seg));
        chk("dp",          32'(dut_dp),          32'(e_dp));
        chk("pending",     32'(dut_pending),     32'(e_pend));
        chk("frame_start", 32'(dut_frame_start), 32'(e_fs));
        if (rst) begin
            m_t = 0; m_pend = 1'b0; m_dig = '0; m_en = '0; m_dp = '0;
            m_blink = '0; m_lz = 1'b0; m_br = '0;
        end else begin
            if (ld) begin
                m_dig = digits; m_en = digit_en; m_dp = dp_in;
                m_blink = blink; m_lz = blank_lz; m_br = brightness;
            end
            m_pend = e_pend;
            m_t++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_update();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; digits = '0; digit_en = '0; dp_in = '0; blink = '0;
        blank_lz = 1'b0; brightness = '0; update = 1'b0;
        m_t = 0; m_pend = 1'b0; m_dig = '0; m_en = '0; m_dp = '0;
        m_blink = '0; m_lz = 1'b0; m_br = '0;
        @(negedge clk);
        run(3);
        reset_n = 1'b1;

        // basic scan at full duty
        digits = 16'h12AF; digit_en = 4'hF; dp_in = 4'b0101; brightness = 2'd3;
        pulse_update();
        run(3 * FRAME);

        // minimum duty
        brightness = 2'd0;
        pulse_update();
        run(2 * FRAME);

        // leading-zero suppression
        brightness = 2'd3; digits = 16'h0050; blank_lz = 1'b1; dp_in = 4'hF;
        pulse_update();
        run(2 * FRAME);
        digits = 16'h0000;
        pulse_update();
        run(2 * FRAME);

        // blink on digit 0
        digits = 16'h4321; blank_lz = 1'b0; blink = 4'b0001;
        pulse_update();
        run(9 * FRAME);

        // update landing exactly on a boundary cycle
        blink = 4'b0000; digits = 16'h9876;
        while (m_t % FRAME != FRAME - 1) step();
        pulse_update();
        run(FRAME);

        // mid-frame update followed by reset discards it
        digits = 16'hBEEF;
        run(10);
        pulse_update();
        run(5);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        run(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            digits     = 16'($urandom) >> (4 * $urandom_range(0, 4));
            digit_en   = 4'($urandom);
            dp_in      = 4'($urandom);
            blink      = 4'($urandom);
            blank_lz   = 1'($urandom);
            brightness = 2'($urandom);
            update     = ($urandom_range(0, 19) == 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;
        update  = 1'b0;
        run(FRAME);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal 2..16.
REQ-002 Parameter SLOT_LOG2, default 17: each digit slot lasts 2^SLOT_LOG2 clk cycles, legal 4..24.
REQ-003 Parameter BRIGHT_BITS, default 3: brightness resolution, legal 1..(SLOT_LOG2-2).
REQ-004 Parameter BLINK_FRAMES, default 64: frames per blink half-period, legal >=1.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 digits  in  4*NUM_DIGITS  hex value per digit; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-008 digit_en  in  NUM_DIGITS  1 = digit i may light.
REQ-009 dp  in  NUM_DIGITS  1 = decimal point i lit.
REQ-010 blink  in  NUM_DIGITS  1 = digit i blinks.
REQ-011 blank_lz  in  1  1 = leading-zero suppression on.
REQ-012 brightness  in  BRIGHT_BITS  duty level; all-ones = full duty.
REQ-013 update  in  1  one-cycle request to load all display inputs into shadow registers.
REQ-014 AN  out  NUM_DIGITS  anode enables, active-low, registered.
REQ-015 sseg  out  7  segments, active-low, sseg[0]=a ... sseg[6]=g, registered.
REQ-016 DP  out  1  decimal point, active-low, registered.
REQ-017 pending  out  1  high while an update request awaits a frame boundary.
REQ-018 frame_start  out  1  one-cycle pulse when the shadow registers load.

Function
REQ-019 Cycle counter cnt (SLOT_LOG2 bits) increments every cycle and wraps; slot index sel advances on cnt all-ones, wrapping NUM_DIGITS-1 -> 0.
REQ-020 A frame boundary is the cycle where cnt is all-ones and sel = NUM_DIGITS-1.
REQ-021 update sets pending; at the frame boundary with pending or update high, shadow registers capture digits, digit_en, dp, blink, blank_lz and brightness sampled that cycle, pending clears, and frame_start pulses the next cycle.
REQ-022 update while pending is already high has no additional effect; update on a boundary cycle loads at that boundary and pending stays 0.
REQ-023 Digit sel is lit in a cycle only if shadow digit_en[sel]=1, it is not LZ-blanked, it is not blink-blanked, cnt != 0 (anti-ghost gap), and cnt[SLOT_LOG2-1 -: BRIGHT_BITS] <= shadow brightness.
REQ-024 LZ blanking: with shadow blank_lz=1, digit i (i>=1) is blanked when shadow digits of i and every higher index are all zero; digit 0 is never LZ-blanked; its dp still displays.
REQ-025 Blink: frame counter counts boundaries to BLINK_FRAMES-1 then wraps, toggling phase; when phase=1, digits with shadow blink=1 are blanked, dp included.
REQ-026 When digit sel is lit: AN has only bit sel low, sseg = active-low hex glyph of the shadow value (0-9, A, b, C, d, E, F), DP = ~shadow dp[sel]; otherwise AN all ones, sseg 7'h7F, DP = 1.
REQ-027 Outputs lag counter state by exactly one clk cycle; at most one AN bit is ever low.

Reset
REQ-028 While reset_n=0 at a rising edge: cnt, sel, frame counter, phase, pending, frame_start and all shadow registers clear to 0; AN all ones, sseg 7'h7F, DP 1.
REQ-029 Reset mid-frame discards a pending update; display stays dark until the first update loads nonzero digit_en.

Structure
REQ-030 Shared package holds the 16-entry glyph constant table and parameter legal-range constants.
REQ-031 One sub-module sseg_glyph (4-bit hex -> 7-bit active-low segments, combinational); all state remains in sseg_scan_ctrl.

Verification (NUM_DIGITS=4, SLOT_LOG2=4, BRIGHT_BITS=2, BLINK_FRAMES=2)
REQ-032 Reset, update with digits=16'h12AF, digit_en=4'hF, brightness=3 -> frame_start one cycle after first boundary; AN sequence 1110,1101,1011,0111 lit cnt 1..15 each slot; sseg 7'h0E,7'h08,7'h24,7'h79.
REQ-033 brightness=0 -> each AN low only for cnt 1..3 of its slot, high otherwise.
REQ-034 digits=16'h0050, blank_lz=1 -> digits 3 and 2 dark, digit 1 shows 7'h12, digit 0 shows 7'h40; 16'h0000 -> only digit 0 lit.
REQ-035 blink=4'b0001 -> digit 0 dark in frames 2-3, 6-7, lit in frames 0-1, 4-5; other digits unaffected.
REQ-036 update mid-frame -> pending=1 until boundary, outputs keep old values; update on boundary cycle -> pending never rises; reset_n=0 with pending=1 -> pending 0, AN 4'hF next cycle.
